// File: rtl/insmem_load_controller.sv
// Sequences the instruction memory port between the byte loader and fetch.
// Ports: loader (i_byte*, o_byte_ready, i_load_start), fetch (i_fetch_*),
// memory (o_mem_*), status (o_load_*, o_overflow, o_state, o_checksum).
// Option: INSMEM_LOAD_CHECKSUM_EN builds the XOR checksum of loaded words.
module insmem_load_controller #(
  parameter int NB_DATA = 16,
  parameter int N_ADDR = 2048,
  parameter int LOG2_N_INSMEM_ADDR = $clog2(N_ADDR),
  parameter logic [NB_DATA-1:0] HALT_WORD = '0
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_load_start,
  input  logic [7:0]                    i_byte,
  input  logic                          i_byte_valid,
  output logic                          o_byte_ready,
  input  logic                          i_run,
  input  logic                          i_fetch_en,
  input  logic [LOG2_N_INSMEM_ADDR-1:0] i_fetch_addr,
  output logic [LOG2_N_INSMEM_ADDR-1:0] o_mem_addr,
  output logic [NB_DATA-1:0]            o_mem_wdata,
  output logic                          o_mem_we,
  output logic                          o_mem_enable,
  output logic                          o_load_done,
  output logic [LOG2_N_INSMEM_ADDR:0]   o_load_count,
  output logic                          o_overflow,
  output logic [1:0]                    o_state,
  output logic [NB_DATA-1:0]            o_checksum
);

  localparam int NBYTES = NB_DATA / 8;
  localparam int BCW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CW = LOG2_N_INSMEM_ADDR + 1;
  localparam logic [CW-1:0] FULL = CW'(N_ADDR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t           state;
  logic [BCW-1:0]   byte_cnt;
  logic [NB_DATA-1:0] word_q;
  logic [CW-1:0]    load_count;
  logic             load_done;
  logic             overflow;
  logic [CW-1:0]    cnt_nxt;

  assign cnt_nxt = load_count + 1'b1;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      word_q     <= '0;
      load_count <= '0;
      load_done  <= 1'b0;
      overflow   <= 1'b0;
    end else if (i_load_start) begin
      // restart beats everything, including a byte offered this cycle
      state      <= LOAD;
      byte_cnt   <= '0;
      word_q     <= '0;
      load_count <= '0;
      load_done  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_byte_valid && load_done && load_count == FULL)
            overflow <= 1'b1;
          if (i_run)
            state <= RUN;
        end
        LOAD: begin
          if (i_byte_valid) begin
            word_q <= (word_q << 8) | NB_DATA'(i_byte);
            if (byte_cnt == BCW'(NBYTES - 1)) begin
              byte_cnt <= '0;
              state    <= WRITE;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          load_count <= cnt_nxt;
          if (word_q == HALT_WORD || cnt_nxt == FULL) begin
            load_done <= 1'b1;
            state     <= IDLE;
          end else begin
            state <= LOAD;
          end
        end
        RUN: begin
          if (!i_run)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // fetch passes straight through in RUN so the PC sees no extra latency
  always_comb begin
    o_mem_addr   = '0;
    o_mem_wdata  = '0;
    o_mem_we     = 1'b0;
    o_mem_enable = 1'b0;
    unique case (state)
      WRITE: begin
        o_mem_addr   = load_count[LOG2_N_INSMEM_ADDR-1:0];
        o_mem_wdata  = word_q;
        o_mem_we     = 1'b1;
        o_mem_enable = 1'b1;
      end
      RUN: begin
        o_mem_addr   = i_fetch_addr;
        o_mem_enable = i_fetch_en;
      end
      default: ;
    endcase
  end

  assign o_byte_ready = (state == LOAD);
  assign o_load_done  = load_done;
  assign o_load_count = load_count;
  assign o_overflow   = overflow;
  assign o_state      = state;

`ifdef INSMEM_LOAD_CHECKSUM_EN
  logic [NB_DATA-1:0] checksum;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset)
      checksum <= '0;
    else if (i_load_start)
      checksum <= '0;
    else if (state == WRITE)
      checksum <= checksum ^ word_q;
  end

  assign o_checksum = checksum;
`else
  assign o_checksum = '0;
`endif

endmodule

// File: tb/tb_insmem_load_controller.sv
// Directed bench for insmem_load_controller with a write scoreboard.
// Runs with N_ADDR=8 so the full/overflow boundary is reachable.
module tb_insmem_load_controller;

  localparam int NB = 16;
  localparam int NA = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_start = 1'b0;
  logic [7:0]    byte_d = '0;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          run = 1'b0;
  logic          fetch_en = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic [AW-1:0] mem_addr;
  logic [NB-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_enable;
  logic          load_done;
  logic [AW:0]   load_count;
  logic          overflow;
  logic [1:0]    state;
  logic [NB-1:0] checksum;

  int n_asrt = 0;
  int n_fail = 0;
  int we_cnt = 0;
  logic [AW+NB-1:0] exp_q[$];

  always #5 clk = ~clk;

  insmem_load_controller #(
    .NB_DATA(NB),
    .N_ADDR(NA),
    .HALT_WORD(16'h0000)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .i_load_start(load_start),
    .i_byte(byte_d),
    .i_byte_valid(byte_valid),
    .o_byte_ready(byte_ready),
    .i_run(run),
    .i_fetch_en(fetch_en),
    .i_fetch_addr(fetch_addr),
    .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata),
    .o_mem_we(mem_we),
    .o_mem_enable(mem_enable),
    .o_load_done(load_done),
    .o_load_count(load_count),
    .o_overflow(overflow),
    .o_state(state),
    .o_checksum(checksum)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_d = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("byte_ready_timeout", 32'd0, 32'd1);
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [AW-1:0] a, input logic [NB-1:0] w);
    exp_q.push_back({a, w});
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {13'd0, mem_addr, mem_wdata}, 32'd0);
      end else begin
        logic [AW+NB-1:0] e;
        e = exp_q.pop_front();
        chk("write_addr_data", {13'd0, mem_addr, mem_wdata}, {13'd0, e});
      end
    end
  end

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_outputs", {mem_addr, mem_wdata, mem_we, mem_enable,
        byte_ready, load_done, load_count, overflow, state},
        32'd0);
    chk("rst_checksum", {16'd0, checksum}, 32'd0);
    rst = 1'b1;
    tick();

    // 1: reset mid-load after one byte
    pulse_start();
    send_byte(8'h11);
    chk("t1_in_load", {30'd0, state}, 32'd1);
    rst = 1'b0;
    #1;
    chk("t1_async_rst", {mem_addr, mem_wdata, mem_we, mem_enable,
        byte_ready, load_done, load_count, overflow, state},
        32'd0);
    tick();
    rst = 1'b1;
    tick();
    byte_d = 8'hAA;
    byte_valid = 1'b1;
    chk("t1_no_ready", {31'd0, byte_ready}, 32'd0);
    tick();
    tick();
    byte_valid = 1'b0;
    chk("t1_idle", {30'd0, state}, 32'd0);
    chk("t1_no_write", we_cnt, 32'd0);

    // 2: three-word load ending in halt word
    we_cnt = 0;
    pulse_start();
    chk("t2_load_state", {30'd0, state}, 32'd1);
    send_word(3'd0, 16'h1234);
    send_word(3'd1, 16'h5678);
    send_word(3'd2, 16'h0000);
    tick();
    chk("t2_count", {28'd0, load_count}, 32'd3);
    chk("t2_done", {31'd0, load_done}, 32'd1);
    chk("t2_state", {30'd0, state}, 32'd0);
    chk("t2_we_cycles", we_cnt, 32'd3);
    chk("t2_queue", exp_q.size(), 32'd0);

    // 3: fill memory, then overflow
    we_cnt = 0;
    pulse_start();
    for (int i = 0; i < NA; i++)
      send_word(AW'(i), {8'hA0 + 8'(i), 8'h5A});
    tick();
    chk("t3_done", {31'd0, load_done}, 32'd1);
    chk("t3_count", {28'd0, load_count}, 32'd8);
    chk("t3_we_cycles", we_cnt, 32'd8);
    chk("t3_no_ovf_yet", {31'd0, overflow}, 32'd0);
    byte_d = 8'hEE;
    byte_valid = 1'b1;
    #1;
    chk("t3_ovf_ready", {31'd0, byte_ready}, 32'd0);
    tick();
    byte_valid = 1'b0;
    tick();
    chk("t3_overflow", {31'd0, overflow}, 32'd1);
    chk("t3_no_extra_we", we_cnt, 32'd8);
    chk("t3_count_hold", {28'd0, load_count}, 32'd8);

    // 4: run mode passthrough
    run = 1'b1;
    tick();
    chk("t4_run_state", {30'd0, state}, 32'd3);
    fetch_en = 1'b1;
    fetch_addr = 3'd5;
    #1;
    chk("t4_addr", {29'd0, mem_addr}, 32'd5);
    chk("t4_enable", {31'd0, mem_enable}, 32'd1);
    chk("t4_no_we", {31'd0, mem_we}, 32'd0);
    fetch_en = 1'b0;
    #1;
    chk("t4_enable_off", {31'd0, mem_enable}, 32'd0);

    // 5: restart from RUN with simultaneous byte
    we_cnt = 0;
    fetch_en = 1'b1;
    byte_d = 8'h77;
    byte_valid = 1'b1;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    byte_valid = 1'b0;
    run = 1'b0;
    chk("t5_state", {30'd0, state}, 32'd1);
    chk("t5_enable", {31'd0, mem_enable}, 32'd0);
    chk("t5_count", {28'd0, load_count}, 32'd0);
    chk("t5_flags", {30'd0, load_done, overflow}, 32'd0);
    fetch_en = 1'b0;
    send_word(3'd0, 16'hBEEF);
    send_word(3'd1, 16'h0000);
    tick();
    chk("t5_we_cycles", we_cnt, 32'd2);
    chk("t5_queue", exp_q.size(), 32'd0);

    // 6: checksum
    pulse_start();
    chk("t6_cks_clear", {16'd0, checksum}, 32'd0);
    send_word(3'd0, 16'h1234);
    send_word(3'd1, 16'h00FF);
    send_word(3'd2, 16'h0000);
    tick();
`ifdef INSMEM_LOAD_CHECKSUM_EN
    chk("t6_checksum", {16'd0, checksum}, 32'h12CB);
`else
    chk("t6_checksum", {16'd0, checksum}, 32'h0000);
`endif
    chk("t6_count", {28'd0, load_count}, 32'd3);
    chk("t6_queue", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/insmem_load_controller.md
Name: insmem_load_controller

Overview:
Sequences the single-port instruction memory between two users: a byte-serial program loader (debug/UART side) and the fetch stage. In LOAD mode it assembles incoming bytes into NB_DATA-bit words and writes them to consecutive addresses. In RUN mode it grants the memory port to fetch. It drives the memory's address, enable and write strobes and reports load status.

Parameters:
NB_DATA, 16, instruction word width; must be a multiple of 8.
N_ADDR, 2048, instruction memory depth in words.
LOG2_N_INSMEM_ADDR, clogb2(N_ADDR), address width.
HALT_WORD, 16'h0000, word value that terminates a load; the halt word itself is written.

Ports:
i_clock  in  1  system clock; all state updates on posedge.
i_reset  in  1  asynchronous, active-low reset.
i_load_start  in  1  single-cycle pulse; begins a load from address 0.
i_byte  in  8  loader byte.
i_byte_valid  in  1  i_byte is valid this cycle.
o_byte_ready  out  1  byte accepted when valid && ready.
i_run  in  1  level; requests transition to RUN.
i_fetch_en  in  1  fetch-stage read enable.
i_fetch_addr  in  LOG2_N_INSMEM_ADDR  fetch address (PC).
o_mem_addr  out  LOG2_N_INSMEM_ADDR  to memory i_addr.
o_mem_wdata  out  NB_DATA  write data.
o_mem_we  out  1  write strobe, one cycle per word.
o_mem_enable  out  1  to memory i_enable.
o_load_done  out  1  level; high from halt/full until next i_load_start.
o_load_count  out  LOG2_N_INSMEM_ADDR+1  words written in the current/last load.
o_overflow  out  1  sticky; load exceeded N_ADDR words.
o_state  out  2  current state encoding.
o_checksum  out  NB_DATA  see Optional Feature.

Behaviour:
- Reset (i_reset=0, async): state=IDLE. All outputs 0: o_mem_addr, o_mem_wdata, o_mem_we, o_mem_enable, o_byte_ready, o_load_done, o_load_count, o_overflow, o_checksum. Byte counter=0. Reset asserted mid-load aborts it; no further write occurs.
- States: IDLE=2'd0, LOAD=2'd1, WRITE=2'd2, RUN=2'd3.
- IDLE:
  - i_load_start -> LOAD; clears o_load_count, o_load_done, o_overflow, byte counter and checksum.
  - else i_run -> RUN.
  - i_load_start has priority over i_run in every state.
- LOAD:
  - o_byte_ready=1.
  - Each accepted byte shifts into the word register MSB-first: the first byte lands in [NB_DATA-1 -:8].
  - When the NB_DATA/8-th byte is accepted -> WRITE.
- WRITE (exactly one cycle):
  - o_mem_we=1, o_mem_enable=1, o_mem_addr=o_load_count[LOG2-1:0], o_mem_wdata=assembled word, o_byte_ready=0.
  - o_load_count increments on the next edge.
  - If word==HALT_WORD or the new count==N_ADDR -> IDLE with o_load_done=1.
  - Otherwise -> LOAD.
- Overflow:
  - A byte offered in IDLE while o_load_done=1 and count==N_ADDR sets o_overflow; the byte is dropped, o_byte_ready=0.
  - Addresses never wrap.
- RUN:
  - o_mem_addr=i_fetch_addr and o_mem_enable=i_fetch_en, combinationally (zero added latency). The memory's own read latency is unchanged.
  - o_mem_we=0, o_byte_ready=0.
  - i_run=0 -> IDLE.
  - i_load_start in RUN -> LOAD next cycle; fetch is disabled from that cycle.
- Outside RUN, o_mem_enable is high only in WRITE; fetch is ignored.
- Partial word at i_load_start: accumulated bytes are discarded.
- Simultaneous i_byte_valid and i_load_start in LOAD: restart wins, the byte is dropped.

Optional Feature:
INSMEM_LOAD_CHECKSUM_EN:
- Defined: o_checksum = XOR of all words written in the current load. It updates on the WRITE edge and clears on i_load_start and on reset.
- Undefined: o_checksum is tied to 0 and no checksum register is built.

Test Plan:
1. Reset with i_reset=0 mid-LOAD after 1 byte -> all outputs 0, state 0; after release, a byte 8'hAA with no i_load_start is not accepted.
2. i_load_start, then bytes 12,34,56,78,00,00 -> writes 16'h1234@0, 16'h5678@1, 16'h0000@2; o_load_count=3, o_load_done=1, state IDLE; o_mem_we high exactly 3 cycles.
3. With N_ADDR=8, HALT_WORD never sent, 16 bytes -> 8 writes, o_load_done=1; a 17th byte sets o_overflow=1 and is not written.
4. i_run=1, i_fetch_en=1, i_fetch_addr=5 -> o_mem_addr=5, o_mem_enable=1 the same cycle; drop i_fetch_en -> o_mem_enable=0.
5. In RUN, pulse i_load_start together with i_byte_valid -> state LOAD next cycle, o_mem_enable=0, byte dropped, count=0.
6. With INSMEM_LOAD_CHECKSUM_EN: load 16'h1234, 16'h00FF, 16'h0000 -> o_checksum=16'h12CB. Without the macro -> o_checksum=0.
